// File: rtl/lcd_pkg.sv
// Shared types and constants for the UART->LCD frame scheduler.
// Refresh sequence: line-1 address, 16 chars, line-2 address, 16 chars.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR1 = 3'd1,
        ST_LINE1 = 3'd2,
        ST_ADDR2 = 3'd3,
        ST_LINE2 = 3'd4
    } lcd_sched_state_t;

    localparam int         FRAME_BYTES    = 32;
    localparam int         CHARS_PER_LINE = 16;
    localparam logic [7:0] LCD_CMD_LINE1  = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2  = 8'hC0;

    // Byte k of a frame; k=0 is the leftmost character of line 1.
    function automatic logic [7:0] frame_char(input logic [255:0] frame,
                                              input logic [4:0]   idx);
        return frame[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_frame_sched_rx_slot_cnt.sv
// RX slot counter: tracks which frame-register slot (1..32) the next UART
// byte lands in and pulses frame_done once the 32nd byte is stored.
// Optional feature: LCD_RX_TIMEOUT_EN discards a stalled partial frame
// after TIMEOUT_CYC idle cycles.
module rx_slot_cnt
    import lcd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ready_rx,
    output logic [5:0] o_ready_cnt,
    output logic       o_frame_done
);

    localparam logic [5:0] LAST_SLOT = 6'(FRAME_BYTES);

    logic tmo_hit;

`ifdef LCD_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    logic [IW-1:0] idle_cnt;

    assign tmo_hit = (idle_cnt == IW'(TIMEOUT_CYC));

    // Idle timer: runs only while a partial frame is outstanding.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_ready_rx || (o_ready_cnt == 6'd1) || tmo_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    // Without the timer a partial frame waits for its remaining bytes forever.
    assign tmo_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    // Slot counter 1..32 with wrap, and a one-cycle frame_done after slot 32.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ready_cnt  <= 6'd1;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= i_ready_rx && (o_ready_cnt == LAST_SLOT);
            if (i_ready_rx)
                o_ready_cnt <= (o_ready_cnt == LAST_SLOT) ? 6'd1 : o_ready_cnt + 6'd1;
            else if (tmo_hit)
                o_ready_cnt <= 6'd1;
        end
    end

endmodule

// File: rtl/lcd_frame_sched.sv
// Top of the UART->LCD frame path sequencer. Counts RX bytes into frame
// slots, latches a snapshot of each completed frame and streams it to the
// HD44780 byte driver as 34 valid/ack writes.
// Optional feature: LCD_RX_TIMEOUT_EN (partial-frame idle timeout).
module lcd_frame_sched
    import lcd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ready_rx,
    output logic [5:0]   o_ready_cnt,
    output logic         o_frame_done,
    input  logic [255:0] i_frame,
    output logic         o_lcd_valid,
    output logic         o_lcd_rs,
    output logic [7:0]   o_lcd_byte,
    input  logic         i_lcd_ack,
    output logic         o_busy,
    output logic         o_overrun
);

    localparam logic [4:0] LINE1_LAST = 5'(CHARS_PER_LINE - 1);
    localparam logic [4:0] LINE2_FIRST = 5'(CHARS_PER_LINE);
    localparam logic [4:0] LINE2_LAST = 5'(FRAME_BYTES - 1);

    lcd_sched_state_t state;
    logic             pending;
    logic [255:0]     snap;
    logic [4:0]       idx;
    logic             start;
    logic             xfer;

    rx_slot_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx_slot_cnt (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ready_rx   (i_ready_rx),
        .o_ready_cnt  (o_ready_cnt),
        .o_frame_done (o_frame_done)
    );

    assign start  = (state == ST_IDLE) && pending;
    assign xfer   = o_lcd_valid && i_lcd_ack;
    assign o_busy = (state != ST_IDLE);

    // Pending flag: frames coalesce; a frame landing on an unserved one is an overrun.
    // A frame_done in the same cycle the refresh starts is kept pending, not dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= o_frame_done && pending && !start;
            if (o_frame_done)
                pending <= 1'b1;
            else if (start)
                pending <= 1'b0;
        end
    end

    // Snapshot isolates the refresh from bytes arriving for the next frame.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            snap <= '0;
        else if (start)
            snap <= i_frame;
    end

    // Write sequencer: outputs are registered and advance only on valid & ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            o_lcd_valid <= 1'b0;
            o_lcd_rs    <= 1'b0;
            o_lcd_byte  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state       <= ST_ADDR1;
                        o_lcd_valid <= 1'b1;
                        o_lcd_rs    <= 1'b0;
                        o_lcd_byte  <= LCD_CMD_LINE1;
                    end
                end
                ST_ADDR1: begin
                    if (xfer) begin
                        state      <= ST_LINE1;
                        idx        <= '0;
                        o_lcd_rs   <= 1'b1;
                        o_lcd_byte <= frame_char(snap, 5'd0);
                    end
                end
                ST_LINE1: begin
                    if (xfer) begin
                        if (idx == LINE1_LAST) begin
                            state      <= ST_ADDR2;
                            o_lcd_rs   <= 1'b0;
                            o_lcd_byte <= LCD_CMD_LINE2;
                        end else begin
                            idx        <= idx + 5'd1;
                            o_lcd_byte <= frame_char(snap, idx + 5'd1);
                        end
                    end
                end
                ST_ADDR2: begin
                    if (xfer) begin
                        state      <= ST_LINE2;
                        idx        <= LINE2_FIRST;
                        o_lcd_rs   <= 1'b1;
                        o_lcd_byte <= frame_char(snap, LINE2_FIRST);
                    end
                end
                ST_LINE2: begin
                    if (xfer) begin
                        if (idx == LINE2_LAST) begin
                            state       <= ST_IDLE;
                            o_lcd_valid <= 1'b0;
                            o_lcd_rs    <= 1'b0;
                            o_lcd_byte  <= '0;
                        end else begin
                            idx        <= idx + 5'd1;
                            o_lcd_byte <= frame_char(snap, idx + 5'd1);
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    o_lcd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
